instruction_fetch_stage: RTL
============================

Name: instruction_fetch_stage

Overview:
IF stage plus IF/ID pipeline register for the MIPS datapath. Owns the PC and runs a req/ready handshake to instruction memory, with a one-entry hold buffer absorbing responses that arrive during a stall. Drives the decoded OpCode straight into the datapath controller. Bubbles present OpCode 6'b111111, the controller's all-zero-control INITIAL code.

Parameters:
ADDR_WIDTH, 32, PC/address width
RESET_PC, 32'h0000_0000, first fetch address after reset
NOP_OPCODE, 6'b111111, OpCode driven when IfIdValid=0

Ports:
Clk  in  1  clock, rising edge
Rst  in  1  asynchronous, active-low reset
Stall  in  1  hazard unit: hold IF/ID and PC
RedirectValid  in  1  taken branch/jump this cycle
RedirectPC  in  ADDR_WIDTH  redirect target; bits[1:0] ignored (forced 0)
ImemReq  out  1  fetch request
ImemAddr  out  ADDR_WIDTH  fetch address; stable while ImemReq=1 and ImemReady=0
ImemReady  in  1  response valid; sampled only when ImemReq=1
ImemData  in  32  instruction word
IfIdValid  out  1  IF/ID holds a real instruction
IfIdInstr  out  32  instruction
IfIdPCPlus4  out  ADDR_WIDTH  fetch address + 4
OpCode  out  6  IfIdInstr[31:26] if IfIdValid, else NOP_OPCODE
FetchPC  out  ADDR_WIDTH  current PC (debug)

Behaviour:
- Reset (Rst=0, async): PC=RESET_PC, state=FETCH, ImemReq=0, ImemAddr=RESET_PC, IfIdValid=0, IfIdInstr=0, IfIdPCPlus4=0, OpCode=NOP_OPCODE, hold buffer empty. ImemReq rises on the first clock after Rst=1.
- Registered FetchAddr drives ImemAddr; loaded from PC when a new request issues.
- States:
 - FETCH: ImemReq=1. When ImemReady and Stall=0: IF/ID <= {ImemData, FetchAddr+4}, IfIdValid=1, PC=FetchAddr+4, next request issues the following cycle (one instruction per cycle at zero-wait memory). When ImemReady and Stall=1: word into hold buffer, PC advances, go HOLD.
 - HOLD: ImemReq=0. IF/ID frozen. When Stall=0: buffer -> IF/ID, IfIdValid=1, go FETCH.
 - DRAIN: ImemReq=1 on the stale FetchAddr. On ImemReady, drop the data and go FETCH at PC.
- Stall=1 with no response: IF/ID and PC hold; the request stays outstanding.
- Redirect priority is Redirect > Stall > normal.
 - RedirectValid=1: PC<=RedirectPC&~3, IfIdValid<=0, hold buffer cleared, regardless of Stall.
 - Redirect with a request outstanding and ImemReady=0: go DRAIN.
 - Redirect coinciding with ImemReady: discard the word, go FETCH.
 - Redirect in HOLD: discard the buffer, go FETCH.
 - Redirect in DRAIN: update PC only; stay in DRAIN.
- PC arithmetic is modulo 2^ADDR_WIDTH: 32'hFFFF_FFFC+4 wraps to 0, no flag.
- OpCode is combinational from the IF/ID register; no other combinational path from inputs to outputs except through the registered state.
- Reset mid-DRAIN/HOLD: all state discarded immediately. The memory must tolerate ImemReq dropping mid-request.

Decomposition:
- Shared package: NOP_OPCODE, the opcode localparams already listed in the datapath controller (single source of truth), state encoding FETCH/HOLD/DRAIN.
- One sub-module: ifid_pipeline_register (Valid/Instr/PCPlus4 with load, flush, hold), reused for later stage registers.

Test Plan:
- Reset release, zero-wait memory returning ADDI (OpCode 001000) at 0x0, 0x4 -> ImemAddr 0x0,0x4,0x8 on consecutive cycles; IfIdPCPlus4 0x4 then 0x8; OpCode 6'b111111 until first valid.
- Stall=1 for 3 cycles while ImemReady=1 at PC 0x8 -> HOLD entered, ImemReq=0, IF/ID unchanged; on Stall=0 IfIdPCPlus4=0xC next edge, no instruction lost or duplicated.
- Memory 3-wait-state fetch at 0x10, RedirectValid=1 with RedirectPC=0x41 on wait cycle 1 -> ImemAddr stays 0x10 until ready, data dropped, next ImemAddr=0x40, IfIdValid=0 throughout.
- Redirect and Stall asserted together with ImemReady=1 -> word discarded, IfIdValid=0, PC=target.
- PC=0xFFFF_FFFC fetch completes -> next ImemAddr=0x0.
- Rst low asynchronously mid-HOLD -> outputs reach reset values before the next clock edge; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_stage_pkg.sv
// Shared definitions for the fetch stage: controller opcodes and fetch FSM encoding.
package instruction_fetch_stage_pkg;

   // Opcodes recognised by the datapath controller
   localparam logic [5:0] OP_RTYPE   = 6'b000000;
   localparam logic [5:0] OP_J       = 6'b000010;
   localparam logic [5:0] OP_JAL     = 6'b000011;
   localparam logic [5:0] OP_BEQ     = 6'b000100;
   localparam logic [5:0] OP_BNE     = 6'b000101;
   localparam logic [5:0] OP_ADDI    = 6'b001000;
   localparam logic [5:0] OP_LW      = 6'b100011;
   localparam logic [5:0] OP_SW      = 6'b101011;
   // Controller INITIAL code: every control line deasserted
   localparam logic [5:0] OP_INITIAL = 6'b111111;

   // Opcode presented to the controller for a bubble
   localparam logic [5:0] NOP_OPCODE = OP_INITIAL;

   // Fetch FSM: FETCH has a request up, HOLD parks a word during a stall,
   // DRAIN swallows the response of a request made stale by a redirect
   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_HOLD  = 2'd1,
      ST_DRAIN = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_stage_ifid.sv
// Generic stage register: Valid/Instr/PCPlus4 with load, flush (valid drop) and hold.
module ifid_pipeline_register #(
   parameter int unsigned ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic                  flush,
   input  logic [31:0]           d_instr,
   input  logic [ADDR_WIDTH-1:0] d_pcplus4,
   output logic                  q_valid,
   output logic [31:0]           q_instr,
   output logic [ADDR_WIDTH-1:0] q_pcplus4
);

   // Flush beats load; with neither asserted the register holds
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_valid   <= 1'b0;
         q_instr   <= '0;
         q_pcplus4 <= '0;
      end else if (flush) begin
         q_valid   <= 1'b0;
      end else if (load) begin
         q_valid   <= 1'b1;
         q_instr   <= d_instr;
         q_pcplus4 <= d_pcplus4;
      end
   end

endmodule

// File: rtl/instruction_fetch_stage.sv
// IF stage: owns the PC, runs the req/ready handshake to instruction memory,
// parks stalled responses in a one-entry buffer and feeds the IF/ID register.
module instruction_fetch_stage
   import instruction_fetch_stage_pkg::*;
#(
   parameter int unsigned           ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
   parameter logic [5:0]            NOP_OPCODE = OP_INITIAL
) (
   input  logic                  Clk,
   input  logic                  Rst,
   input  logic                  Stall,
   input  logic                  RedirectValid,
   input  logic [ADDR_WIDTH-1:0] RedirectPC,
   output logic                  ImemReq,
   output logic [ADDR_WIDTH-1:0] ImemAddr,
   input  logic                  ImemReady,
   input  logic [31:0]           ImemData,
   output logic                  IfIdValid,
   output logic [31:0]           IfIdInstr,
   output logic [ADDR_WIDTH-1:0] IfIdPCPlus4,
   output logic [5:0]            OpCode,
   output logic [ADDR_WIDTH-1:0] FetchPC
);

   fetch_state_t          state_reg, state_next;
   logic [ADDR_WIDTH-1:0] pc_reg, pc_next;
   logic [ADDR_WIDTH-1:0] fetch_addr_reg, fetch_addr_next;
   logic                  req_reg, req_next;
   logic                  hold_valid_reg, hold_valid_next;
   logic [31:0]           hold_instr_reg, hold_instr_next;
   logic [ADDR_WIDTH-1:0] hold_pcplus4_reg, hold_pcplus4_next;

   logic                  ifid_load, ifid_flush, issue;
   logic [31:0]           ifid_d_instr;
   logic [ADDR_WIDTH-1:0] ifid_d_pcplus4;
   logic [ADDR_WIDTH-1:0] fetch_plus4, redirect_pc;
   logic                  resp;

   // Address arithmetic wraps naturally at 2^ADDR_WIDTH
   assign fetch_plus4 = fetch_addr_reg + ADDR_WIDTH'(4);
   assign redirect_pc = RedirectPC & ~ADDR_WIDTH'(3);
   // Ready only counts while a request is actually up
   assign resp        = req_reg & ImemReady;

   // State, PC, fetch address, request line and hold buffer
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state_reg        <= ST_FETCH;
         pc_reg           <= RESET_PC;
         fetch_addr_reg   <= RESET_PC;
         req_reg          <= 1'b0;
         hold_valid_reg   <= 1'b0;
         hold_instr_reg   <= '0;
         hold_pcplus4_reg <= '0;
      end else begin
         state_reg        <= state_next;
         pc_reg           <= pc_next;
         fetch_addr_reg   <= fetch_addr_next;
         req_reg          <= req_next;
         hold_valid_reg   <= hold_valid_next;
         hold_instr_reg   <= hold_instr_next;
         hold_pcplus4_reg <= hold_pcplus4_next;
      end
   end

   // Next-state, PC update and IF/ID control; redirect overrides stall overrides normal flow
   always_comb begin
      state_next        = state_reg;
      pc_next           = pc_reg;
      hold_valid_next   = hold_valid_reg;
      hold_instr_next   = hold_instr_reg;
      hold_pcplus4_next = hold_pcplus4_reg;
      ifid_load         = 1'b0;
      ifid_flush        = 1'b0;
      ifid_d_instr      = ImemData;
      ifid_d_pcplus4    = fetch_plus4;
      issue             = 1'b0;

      case (state_reg)
         ST_FETCH: begin
            if (!req_reg) begin
               // first cycle out of reset: raise the request at the PC
               issue = 1'b1;
            end else if (resp) begin
               pc_next = fetch_plus4;
               if (Stall) begin
                  hold_valid_next   = 1'b1;
                  hold_instr_next   = ImemData;
                  hold_pcplus4_next = fetch_plus4;
                  state_next        = ST_HOLD;
               end else begin
                  ifid_load = 1'b1;
                  issue     = 1'b1;
               end
            end
         end
         ST_HOLD: begin
            if (!Stall) begin
               ifid_load       = hold_valid_reg;
               ifid_d_instr    = hold_instr_reg;
               ifid_d_pcplus4  = hold_pcplus4_reg;
               hold_valid_next = 1'b0;
               state_next      = ST_FETCH;
               issue           = 1'b1;
            end
         end
         ST_DRAIN: begin
            if (resp) begin
               state_next = ST_FETCH;
               issue      = 1'b1;
            end
         end
         default: state_next = ST_FETCH;
      endcase

      if (RedirectValid) begin
         pc_next         = redirect_pc;
         ifid_load       = 1'b0;
         ifid_flush      = 1'b1;
         hold_valid_next = 1'b0;
         if (state_reg == ST_FETCH && req_reg && !ImemReady) begin
            // address must stay stable until memory answers, so swallow that answer
            state_next = ST_DRAIN;
            issue      = 1'b0;
         end else if (state_reg != ST_DRAIN) begin
            state_next = ST_FETCH;
            issue      = 1'b1;
         end
      end else if (!Stall && !ifid_load) begin
         // decode consumed its instruction and nothing replaces it
         ifid_flush = 1'b1;
      end
   end

   assign fetch_addr_next = issue ? pc_next : fetch_addr_reg;
   assign req_next        = (state_next != ST_HOLD);

   ifid_pipeline_register #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ifid (
      .clk       (Clk),
      .rst_n     (Rst),
      .load      (ifid_load),
      .flush     (ifid_flush),
      .d_instr   (ifid_d_instr),
      .d_pcplus4 (ifid_d_pcplus4),
      .q_valid   (IfIdValid),
      .q_instr   (IfIdInstr),
      .q_pcplus4 (IfIdPCPlus4)
   );

   assign ImemReq  = req_reg;
   assign ImemAddr = fetch_addr_reg;
   assign FetchPC  = pc_reg;
   assign OpCode   = IfIdValid ? IfIdInstr[31:26] : NOP_OPCODE;

endmodule
